// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipe_hazard_ctrl (slave).
// stall_cnt is present only when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_Rn;
  logic [4:0]  id_Rm;
  logic        id_use_Rn;
  logic        id_use_Rm;
  logic        ex_mem_read;
  logic [4:0]  ex_Rd;
  logic        mem_req;
  logic        mem_ready;
  logic        br_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_bubble;
  logic        mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  modport master (
    output id_Rn, id_Rm, id_use_Rn, id_use_Rm, ex_mem_read, ex_Rd,
           mem_req, mem_ready, br_taken,
    input  pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_Rn, id_Rm, id_use_Rn, id_use_Rm, ex_mem_read, ex_Rd,
           mem_req, mem_ready, br_taken,
    output pc_en, ifid_en, idex_en, exmem_en,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing controller: load-use interlock, branch flush, bounded memory wait.
// Optional stall-cycle counter enabled by the HAZ_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // Control vector order: pc, ifid, idex, exmem enables, then ifid/idex/exmem flush, memwb bubble
  localparam logic [7:0] CTL_RUN    = 8'b1111_0000;
  localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;
  localparam logic [7:0] CTL_BRANCH = 8'b1111_1110;
  localparam logic [7:0] CTL_LU     = 8'b0011_0100;
  localparam logic [7:0] CTL_ABORT  = 8'b1111_0011;

  state_t      state_r;
  state_t      state_nxt;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_cnt_nxt;
  logic        mem_err_r;
  logic        err_set;
  logic        lu;
  logic        mem_stall;
  logic [7:0]  ctl;

  assign lu = hif.ex_mem_read && (hif.ex_Rd != 5'd31) &&
              ((hif.id_use_Rn && (hif.ex_Rd == hif.id_Rn)) ||
               (hif.id_use_Rm && (hif.ex_Rd == hif.id_Rm)));
  assign mem_stall = hif.mem_req && !hif.mem_ready;

  // Next-state and control decode from current state and hazard inputs
  always_comb begin
    ctl          = CTL_RUN;
    state_nxt    = RUN;
    wait_cnt_nxt = 16'd0;
    err_set      = 1'b0;
    case (state_r)
      RUN, DRAIN: begin
        if (mem_stall) begin
          ctl          = CTL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end else if (hif.br_taken) begin
          ctl       = CTL_BRANCH;
          state_nxt = (state_r == RUN) ? DRAIN : RUN;
        end else if (lu && (state_r == RUN)) begin
          ctl = CTL_LU;
        end else begin
          ctl = CTL_RUN;
        end
      end
      MEM_WAIT: begin
        if (hif.mem_ready) begin
          if (hif.br_taken) begin
            ctl       = CTL_BRANCH;
            state_nxt = DRAIN;
          end else if (lu) begin
            ctl = CTL_LU;
          end else begin
            ctl = CTL_RUN;
          end
        end else if (wait_cnt_r >= 16'(MEM_TIMEOUT)) begin
          ctl     = CTL_ABORT;
          err_set = 1'b1;
        end else begin
          ctl          = CTL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;
        end
      end
      default: begin
        ctl       = CTL_RUN;
        state_nxt = RUN;
      end
    endcase
  end

  assign {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en,
          hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_bubble} =
         rst ? CTL_RUN : ctl;
  assign hif.mem_err = mem_err_r;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 16'd0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      wait_cnt_r <= wait_cnt_nxt;
      mem_err_r  <= mem_err_r | err_set;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Counts cycles in which fetch is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (!ctl[7]) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hif.stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage 64-bit ARM pipeline. Generates per-stage enable and flush/bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Handles load-use interlocks, taken-branch flushes and multi-cycle data-memory waits, and includes a bounded-wait timeout. Sits beside the pipeline registers; its enables drive their `singleReg` enable and reset/bubble inputs.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive `MEM_WAIT` cycles before abort (≥2).
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_Rn`, `id_Rm`  in  5 each  source registers of the instruction in ID.
- `id_use_Rn`, `id_use_Rm`  in  1 each  ID instruction actually reads that source.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_Rd`  in  5  destination of the EX instruction.
- `mem_req`  in  1  instruction in MEM accesses data memory (load or store).
- `mem_ready`  in  1  data memory completes the access this cycle.
- `br_taken`  in  1  branch resolved taken in MEM.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1 each  register hold controls (1 = load).
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_bubble`  out  1 each  load an all-zero control bundle (NOP) next edge.
- `mem_err`  out  1  sticky: a memory access timed out.
- `stall_cnt`  out  32  stall-cycle counter (only with `HAZ_PERF_CNT_EN`).

## Operation
- FSM states:
  - `RUN`: normal flow.
  - `MEM_WAIT`: whole pipeline frozen on memory.
  - `DRAIN`: one cycle after a branch flush.
- Register 31 (XZR) never creates a hazard.
- Load-use hazard `lu`: `ex_mem_read` && `ex_Rd`≠31 && ((`id_use_Rn` && `ex_Rd`==`id_Rn`) || (`id_use_Rm` && `ex_Rd`==`id_Rm`)).
- **RUN**, evaluated in priority order:
  1. `mem_req` && !`mem_ready`: `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0, `memwb_bubble`=1. Next state `MEM_WAIT`, wait counter ← 1.
  2. `br_taken`: all enables 1; `ifid_flush`=`idex_flush`=`exmem_flush`=1. Next state `DRAIN`.
  3. `lu`: `pc_en`=`ifid_en`=0, `idex_flush`=1, others 1. Stay in `RUN`.
  4. Otherwise: all enables 1, all flushes/bubble 0.
- **MEM_WAIT**:
  - Outputs frozen as in rule 1.
  - `mem_ready`: evaluate the `RUN` rules 2–4 combinationally this cycle, with all enables released. Next state `DRAIN` if `br_taken`, else `RUN`.
  - Wait counter reaches `MEM_TIMEOUT` without `mem_ready`: set `mem_err`, `memwb_bubble`=1, `exmem_flush`=1, enables 1 (the access is dropped). Next state `RUN`.
  - `br_taken` during a wait is ignored until release; its inputs are held because EX/MEM is frozen.
- **DRAIN**: `lu` suppressed (ID holds a flushed NOP). `mem_req` stall rules still apply. Next state `RUN` unless entering `MEM_WAIT`.
- `mem_err` clears only on `rst`.

## Timing
- All control outputs are combinational from state plus current inputs, so they take effect at the next `clk` edge. State, wait counter, `mem_err` and `stall_cnt` are registered.
- Reset (asynchronous, any cycle including mid-`MEM_WAIT`):
  - state `RUN`, wait counter 0, `mem_err`=0, `stall_cnt`=0.
  - Outputs while `rst` is high: all enables 1, all flushes/bubble 0.
- Load-use costs exactly 1 bubble cycle; the dependent instruction re-decodes the next cycle with `lu`=0.
- Branch penalty is 3 flushed slots in 1 cycle.
- Memory stall length N = cycles until `mem_ready`, bounded by `MEM_TIMEOUT`.
- Wait counter is 16 bits and saturates; there is no wrap.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every cycle where `pc_en`=0.
  - Wraps modulo 2^32.
  - Held at 0 by `rst`.
- Not defined: `stall_cnt` port and counter are absent. All other behaviour is identical.

## Test plan
- Load `ex_Rd`=3, `ex_mem_read`=1; ID `id_Rn`=3, `id_use_Rn`=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1, then all-run. The same case with `ex_Rd`=31 → no stall.
- `br_taken`=1 in `RUN` with a concurrent `lu` condition → the three flushes fire and `pc_en`=1. Next cycle is `DRAIN`, where an `lu` match produces no stall.
- `mem_req`=1, `mem_ready` low for 4 cycles then high → 4 cycles with all enables 0 and `memwb_bubble`=1, release on the 5th cycle, `stall_cnt`=4 (macro on).
- `MEM_TIMEOUT`=16, `mem_ready` never rises → `mem_err`=1 after 16 wait cycles, `exmem_flush`=1 that cycle, back to `RUN`. `mem_err` stays 1 until `rst`.
- Assert `rst` in the 2nd cycle of `MEM_WAIT` → state `RUN`, enables 1, `mem_err`=0, `stall_cnt`=0 immediately (asynchronous).
- `mem_ready` and held `br_taken` on the release cycle → flushes fire that cycle, enables 1, next state `DRAIN`.
